jaxa_link_control: RTL
======================

Name: jaxa_link_control

Overview:
- Avalon-MM slave output port that drives SpaceWire link control bits (link start, autostart, disable, tx divider select) from the host CPU.
- Write-side counterpart of the link-status input port.
- Provides a level register (out_port) and a self-clearing command-pulse register (pulse_port) with a programmable pulse length.
- Sits between the system interconnect and the SpaceWire link FSM control inputs.

Parameters:
- DATA_WIDTH, 16, width of out_port and pulse_port (1..32).
- RESET_VALUE, 0, value loaded into the level register on reset (DATA_WIDTH bits).
- PULSE_LEN, 8, number of clk cycles each command pulse is held (1..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  3  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  input  32  write data; bits above DATA_WIDTH-1 ignored.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  level control bits (= level register).
- pulse_port  output  DATA_WIDTH  command pulse bits (= pulse register).
- busy  output  1  high while any pulse bit is active.

Behaviour:
- One clock domain; async active-high reset. No wait states; every write completes in one cycle.
- Register map:
  - 0 DATA (RW): level register.
  - 1 STATUS (RO): bit0 = busy.
  - 3 PULSE (RW): pulse register; a write ORs bits in.
  - 4 OUTSET (WO, macro): set bits in level register.
  - 5 OUTCLR (WO, macro): clear bits in level register.
  - 2, 6, 7: reserved; read 0, writes ignored.
- Reset values: level register = RESET_VALUE; pulse register = 0; counter = 0; readdata = 0; busy = 0.
- DATA write: level register <= writedata[DATA_WIDTH-1:0] at the write edge. out_port shows the new value in the cycle after the write.
- PULSE write with nonzero data:
  - pulse register <= pulse register | data.
  - Counter loaded with PULSE_LEN-1.
  - pulse_port and busy assert in the cycle after the write.
- PULSE write with zero data: no effect. The counter is not reloaded.
- Pulse countdown: while the pulse register != 0 and there is no PULSE write, the counter decrements each cycle.
  - When the counter is 0 the pulse register clears on that edge.
  - Each pulse is therefore high for exactly PULSE_LEN cycles. With PULSE_LEN=1 it is high for one cycle.
- Retrigger: a nonzero PULSE write while busy ORs in the new bits and reloads the counter; all set bits then stay high PULSE_LEN more cycles.
  - This applies even when the counter is 0 in the same cycle (the write wins; no clear).
- busy = OR-reduce of the pulse register (combinational from the register).
- Reads:
  - readdata updates on every clk edge regardless of chipselect, so read latency is 1 cycle.
  - addr0 -> zero-extended level register; addr1 -> {31'b0, busy}; addr3 -> zero-extended pulse register; all others -> 0.
  - A read in the same cycle as a write to the same register returns the old value.
- Reset asserted mid-pulse: pulse register and counter clear immediately (async); pulse_port and busy drop without waiting for a clock; out_port = RESET_VALUE.
- Counter width: 16 bits, unsigned, never wraps. It only loads or decrements while nonzero.

Optional Feature:
- Macro: JAXA_LINK_CONTROL_BITSET_EN.
- Defined: addr4 write does level <= level | data; addr5 write does level <= level & ~data. Both take effect at the write edge; reads of 4 and 5 return 0.
- Undefined: addresses 4 and 5 are reserved (writes ignored, read 0). No set/clear logic is synthesised.

Test Plan:
- Reset with RESET_VALUE=16'h0005 -> out_port=0005, pulse_port=0, busy=0, readdata=0. Read addr0 one cycle later -> 0x00000005.
- Write addr0 0xFFFF1234 -> out_port=1234 the next cycle; read addr0 -> 0x00001234; read addr2 -> 0.
- PULSE_LEN=8; write addr3 0x0001 -> pulse_port=0001 and busy=1 for exactly 8 cycles, then 0. Read addr1 mid-pulse -> 0x00000001.
- Write addr3 0x0001, then 5 cycles later write addr3 0x0002 -> pulse_port=0003 for 8 cycles after the second write; bit0 high 13 cycles total. Write addr3 0 while idle -> no pulse.
- Start a pulse, assert reset asynchronously between clock edges at cycle 3 -> pulse_port and busy drop before the next clk edge; after reset release, no residual pulse.
- With JAXA_LINK_CONTROL_BITSET_EN: level=00F0, write addr4 0x000F -> 00FF, write addr5 0x0030 -> 00CF. Without the macro, the same writes leave out_port=00F0.

Source files
------------

// File: rtl/jaxa_link_control.sv
// jaxa_link_control
//   Avalon-MM slave output port driving SpaceWire link control bits from the
//   host CPU. Holds a level register (out_port) and a self-clearing command
//   pulse register (pulse_port). Every set pulse bit stays high for PULSE_LEN
//   cycles after the most recent nonzero PULSE write.
//
// Register map:
//   0 DATA   (RW) level register
//   1 STATUS (RO) bit0 = busy
//   3 PULSE  (RW) pulse register, writes OR bits in
//   4 OUTSET (WO) set level bits   -- only with JAXA_LINK_CONTROL_BITSET_EN
//   5 OUTCLR (WO) clear level bits -- only with JAXA_LINK_CONTROL_BITSET_EN
//   other addresses read 0 and ignore writes.
//
// Optional feature macro: JAXA_LINK_CONTROL_BITSET_EN
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (bits above DATA_WIDTH-1 ignored)
//   readdata   registered read data (1-cycle latency)
//   out_port   level control bits
//   pulse_port command pulse bits
//   busy       high while any pulse bit is set
module jaxa_link_control #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           PULSE_LEN   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] pulse_port,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_STATUS = 3'd1,
    ADDR_RSVD2  = 3'd2,
    ADDR_PULSE  = 3'd3,
    ADDR_OUTSET = 3'd4,
    ADDR_OUTCLR = 3'd5,
    ADDR_RSVD6  = 3'd6,
    ADDR_RSVD7  = 3'd7
  } reg_addr_e;

  reg_addr_e             sel;
  logic                  wr;
  logic                  pulse_wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] level;
  logic [DATA_WIDTH-1:0] pulse;
  logic [15:0]           count;
  logic [31:0]           rd_next;

  assign sel      = reg_addr_e'(address);
  assign wr       = chipselect & ~write_n;
  assign wdata    = writedata[DATA_WIDTH-1:0];
  // A zero PULSE write must neither set bits nor reload the counter.
  assign pulse_wr = wr && (sel == ADDR_PULSE) && (wdata != '0);

  if (DATA_WIDTH < 32) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^writedata[31:DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= RESET_VALUE;
    end else if (wr) begin
      case (sel)
        ADDR_DATA:   level <= wdata;
`ifdef JAXA_LINK_CONTROL_BITSET_EN
        ADDR_OUTSET: level <= level | wdata;
        ADDR_OUTCLR: level <= level & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  // Counter holds remaining cycles minus one; the pulse clears on the edge
  // where it is already zero. A retrigger write takes priority over clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse <= '0;
      count <= '0;
    end else if (pulse_wr) begin
      pulse <= pulse | wdata;
      count <= 16'(PULSE_LEN - 1);
    end else if (pulse != '0) begin
      if (count == '0) pulse <= '0;
      else             count <= count - 16'd1;
    end
  end

  always_comb begin
    rd_next = '0;
    case (sel)
      ADDR_DATA:   rd_next[DATA_WIDTH-1:0] = level;
      ADDR_STATUS: rd_next[0]              = busy;
      ADDR_PULSE:  rd_next[DATA_WIDTH-1:0] = pulse;
      default:     rd_next                 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign out_port   = level;
  assign pulse_port = pulse;
  assign busy       = |pulse;

endmodule
